// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared state, class and control-field encodings for mc_ctrl
package mc_ctrl_pkg;

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;

   typedef enum logic [3:0] {
      C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH,
      C_J, C_JAL, C_JR, C_JALR, C_ILL
   } iclass_t;

   // ALU operation codes; the top zero-extends these to ALUOP_W
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_NOR  = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;
   localparam logic [1:0] NPC_REG = 2'b11;

   localparam logic [1:0] GPR_RD  = 2'b00;
   localparam logic [1:0] GPR_RT  = 2'b01;
   localparam logic [1:0] GPR_R31 = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_MEM = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   localparam logic [1:0] MEM_B = 2'b00;
   localparam logic [1:0] MEM_H = 2'b01;
   localparam logic [1:0] MEM_W = 2'b10;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_JALR = 6'h09;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational Op/Funct decode into instruction class and control fields
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   output iclass_t    o_cls,
   output logic       o_bne,
   output logic [3:0] o_alu_op,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic       o_ext_op,
   output logic [1:0] o_mem_op,
   output logic [1:0] o_gpr_sel,
   output logic [1:0] o_wd_sel
);

   always_comb begin
      o_cls       = C_ILL;
      o_bne       = 1'b0;
      o_alu_op    = ALU_ADD;
      o_alu_src_a = 1'b0;
      o_alu_src_b = 1'b0;
      o_ext_op    = 1'b0;
      o_mem_op    = MEM_W;
      o_gpr_sel   = GPR_RD;
      o_wd_sel    = WD_ALU;
      case (i_op)
         OP_RTYPE: begin
            o_cls = C_ALU_R;
            case (i_funct)
               F_ADD, F_ADDU: o_alu_op = ALU_ADD;
               F_SUB, F_SUBU: o_alu_op = ALU_SUB;
               F_AND:         o_alu_op = ALU_AND;
               F_OR:          o_alu_op = ALU_OR;
               F_NOR:         o_alu_op = ALU_NOR;
               F_XOR:         o_alu_op = ALU_XOR;
               F_SLT:         o_alu_op = ALU_SLT;
               F_SLTU:        o_alu_op = ALU_SLTU;
               // fixed shifts take the amount from shamt, variable ones from rs
               F_SLL: begin o_alu_op = ALU_SLL; o_alu_src_a = 1'b1; end
               F_SRL: begin o_alu_op = ALU_SRL; o_alu_src_a = 1'b1; end
               F_SRA: begin o_alu_op = ALU_SRA; o_alu_src_a = 1'b1; end
               F_SLLV:        o_alu_op = ALU_SLL;
               F_SRLV:        o_alu_op = ALU_SRL;
               F_SRAV:        o_alu_op = ALU_SRA;
               F_JR:          o_cls = C_JR;
               F_JALR: begin
                  o_cls     = C_JALR;
                  o_gpr_sel = GPR_R31;
                  o_wd_sel  = WD_PC;
               end
               default:       o_cls = C_ILL;
            endcase
         end
         OP_ADDI, OP_SLTI: begin
            o_cls       = C_ALU_I;
            o_alu_op    = (i_op == OP_ADDI) ? ALU_ADD : ALU_SLT;
            o_alu_src_b = 1'b1;
            o_ext_op    = 1'b1;
            o_gpr_sel   = GPR_RT;
         end
         OP_ANDI, OP_ORI, OP_LUI: begin
            o_cls       = C_ALU_I;
            o_alu_op    = (i_op == OP_ANDI) ? ALU_AND : ((i_op == OP_ORI) ? ALU_OR : ALU_LUI);
            o_alu_src_b = 1'b1;
            o_gpr_sel   = GPR_RT;
         end
         OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
            o_cls       = C_LOAD;
            o_alu_src_b = 1'b1;
            o_ext_op    = 1'b1;
            o_gpr_sel   = GPR_RT;
            o_wd_sel    = WD_MEM;
            if (i_op == OP_LB || i_op == OP_LBU)
               o_mem_op = MEM_B;
            else if (i_op == OP_LH || i_op == OP_LHU)
               o_mem_op = MEM_H;
         end
         OP_SB, OP_SH, OP_SW: begin
            o_cls       = C_STORE;
            o_alu_src_b = 1'b1;
            o_ext_op    = 1'b1;
            if (i_op == OP_SB)
               o_mem_op = MEM_B;
            else if (i_op == OP_SH)
               o_mem_op = MEM_H;
         end
         OP_BEQ, OP_BNE: begin
            o_cls    = C_BRANCH;
            o_bne    = (i_op == OP_BNE);
            o_alu_op = ALU_SUB;
            o_ext_op = 1'b1;
         end
         OP_J:  o_cls = C_J;
         OP_JAL: begin
            o_cls     = C_JAL;
            o_gpr_sel = GPR_R31;
            o_wd_sel  = WD_PC;
         end
         default: o_cls = C_ILL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle IF/ID/EX/MEM/WB control FSM with trap state and retire counter
module mc_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4,
   parameter int CNT_W   = 32,
   parameter int TRAP_EN = 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         Op,
   input  logic [5:0]         Funct,
   input  logic               Zero,
   input  logic               mem_rdy,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               ALUSrcA,
   output logic               ALUSrcB,
   output logic [1:0]         NPCOp,
   output logic [1:0]         GPRSel,
   output logic [1:0]         WDSel,
   output logic               EXTOp,
   output logic [1:0]         memOp,
   output logic               illegal,
   output logic               retire,
   output logic [CNT_W-1:0]   icount
);

   state_t           r_state;
   state_t           w_next;
   logic             r_illegal;
   logic [CNT_W-1:0] r_icount;

   iclass_t    w_cls;
   logic       w_bne;
   logic [3:0] w_alu_op;
   logic       w_pc_write;
   logic       w_ir_write;
   logic       w_reg_write;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_retire;
   logic [1:0] w_npc_op;

   mc_decode u_decode (
      .i_op        (Op),
      .i_funct     (Funct),
      .o_cls       (w_cls),
      .o_bne       (w_bne),
      .o_alu_op    (w_alu_op),
      .o_alu_src_a (ALUSrcA),
      .o_alu_src_b (ALUSrcB),
      .o_ext_op    (EXTOp),
      .o_mem_op    (memOp),
      .o_gpr_sel   (GPRSel),
      .o_wd_sel    (WDSel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IF;
         r_illegal <= 1'b0;
         r_icount  <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP)
            r_illegal <= 1'b1;
         if (w_retire)
            r_icount <= r_icount + CNT_W'(1);
      end
   end

   always_comb begin
      w_next      = r_state;
      w_pc_write  = 1'b0;
      w_ir_write  = 1'b0;
      w_reg_write = 1'b0;
      w_mem_read  = 1'b0;
      w_mem_write = 1'b0;
      w_retire    = 1'b0;
      w_npc_op    = NPC_PC4;
      case (r_state)
         S_IF: begin
            w_mem_read = 1'b1;
            if (mem_rdy) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_next     = S_ID;
            end
         end
         S_ID: begin
            case (w_cls)
               C_J: begin
                  w_pc_write = 1'b1;
                  w_npc_op   = NPC_J;
                  w_retire   = 1'b1;
                  w_next     = S_IF;
               end
               C_JAL: w_next = S_WB;
               C_ILL: begin
                  if (TRAP_EN != 0) begin
                     w_next = S_TRAP;
                  end else begin
                     w_retire = 1'b1;
                     w_next   = S_IF;
                  end
               end
               default: w_next = S_EX;
            endcase
         end
         S_EX: begin
            case (w_cls)
               C_ALU_R, C_ALU_I: w_next = S_WB;
               C_LOAD, C_STORE:  w_next = S_MEM;
               C_BRANCH: begin
                  w_pc_write = w_bne ? ~Zero : Zero;
                  w_npc_op   = NPC_BR;
                  w_retire   = 1'b1;
                  w_next     = S_IF;
               end
               C_JR: begin
                  w_pc_write = 1'b1;
                  w_npc_op   = NPC_REG;
                  w_retire   = 1'b1;
                  w_next     = S_IF;
               end
               C_JALR: begin
                  w_pc_write = 1'b1;
                  w_npc_op   = NPC_REG;
                  w_next     = S_WB;
               end
               default: w_next = S_IF;
            endcase
         end
         S_MEM: begin
            if (w_cls == C_STORE)
               w_mem_write = 1'b1;
            else
               w_mem_read = 1'b1;
            if (mem_rdy) begin
               if (w_cls == C_STORE) begin
                  w_retire = 1'b1;
                  w_next   = S_IF;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            w_reg_write = 1'b1;
            w_retire    = 1'b1;
            w_next      = S_IF;
            // jal links here and redirects the PC in the same cycle
            if (w_cls == C_JAL) begin
               w_pc_write = 1'b1;
               w_npc_op   = NPC_J;
            end
         end
         S_TRAP: w_next = S_TRAP;
         default: w_next = S_IF;
      endcase
   end

   // strobes are forced low in a reset cycle so an abandoned instruction writes nothing
   assign PCWrite  = w_pc_write  & ~rst;
   assign IRWrite  = w_ir_write  & ~rst;
   assign RegWrite = w_reg_write & ~rst;
   assign MemRead  = w_mem_read  & ~rst;
   assign MemWrite = w_mem_write & ~rst;
   assign retire   = w_retire    & ~rst;
   assign NPCOp    = w_npc_op;
   assign ALUOp    = ALUOP_W'(w_alu_op);
   assign illegal  = r_illegal;
   assign icount   = r_icount;

endmodule
